// File: rtl/dl_pkg.sv
// Shared definitions for the ioctl download path: widths reused by emu and the bridge FSM states.
package dl_pkg;

  localparam int unsigned DL_ADDR_W  = 25;
  localparam int unsigned DL_INDEX_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } dl_state_e;

endpackage

// File: rtl/dl_fifo.sv
// Synchronous FIFO with full/empty flags, occupancy count and a synchronous clear.
module dl_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ioctl_dl_bridge.sv
// Buffers the HPS ioctl download stream into system's dn_* write port with flow control,
// range checking, byte counting and download start/done signalling.
module ioctl_dl_bridge
  import dl_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 17
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ioctl_download,
  input  logic                  ioctl_wr,
  input  logic [DL_ADDR_W-1:0]  ioctl_addr,
  input  logic [7:0]            ioctl_dout,
  input  logic [DL_INDEX_W-1:0] ioctl_index,
  output logic                  ioctl_wait,
  input  logic                  dn_ready,
  output logic [ADDR_W-1:0]     dn_addr,
  output logic [7:0]            dn_data,
  output logic [DL_INDEX_W-1:0] dn_index,
  output logic                  dn_wr,
  output logic                  dl_active,
  output logic                  dl_done,
  output logic [DL_ADDR_W-1:0]  dl_bytes,
  output logic                  dl_error
);

  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned Width = ADDR_W + 8;

  dl_state_e state_q, state_d;

  logic                  start, push_req, in_range, push_ok, avail, pop;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [Width-1:0]      fifo_rdata, in_word, head;
  logic [CntW-1:0]       fifo_count, occ_next;

  logic                  ioctl_wait_q, dn_wr_q, dl_error_q;
  logic [ADDR_W-1:0]     dn_addr_q;
  logic [7:0]            dn_data_q;
  logic [DL_INDEX_W-1:0] dn_index_q;
  logic [DL_ADDR_W-1:0]  dl_bytes_q;

  assign start    = (state_q == StIdle) && ioctl_download;
  assign push_req = (state_q == StLoad) && ioctl_wr;
  assign in_range = ((ioctl_addr >> ADDR_W) == '0);
  assign push_ok  = push_req && in_range && !fifo_full;
  assign in_word  = {ioctl_addr[ADDR_W-1:0], ioctl_dout};

  // An empty FIFO passes the incoming byte straight to the output stage for one-cycle latency.
  assign avail     = !fifo_empty || push_ok;
  assign pop       = avail && dn_ready;
  assign head      = fifo_empty ? in_word : fifo_rdata;
  assign fifo_push = push_ok && !(fifo_empty && dn_ready);
  assign fifo_pop  = pop && !fifo_empty;
  assign occ_next  = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);

  dl_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (Width)
  ) u_fifo (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .clr_i   (start),
    .push_i  (fifo_push),
    .wdata_i (in_word),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ioctl_download) state_d = StLoad;
      StLoad:  if (!ioctl_download) state_d = StDrain;
      StDrain: if (fifo_empty && !dn_wr_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ioctl_wait_q <= 1'b0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      dn_index_q   <= '0;
      dl_bytes_q   <= '0;
      dl_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      // One entry of margin so the HPS can react before the FIFO actually fills.
      ioctl_wait_q <= (occ_next >= CntW'(DEPTH - 1));
      dn_wr_q      <= pop;
      if (pop) {dn_addr_q, dn_data_q} <= head;
      if (start) begin
        dn_index_q <= ioctl_index;
        dl_bytes_q <= '0;
        dl_error_q <= 1'b0;
      end else begin
        if (pop && !(&dl_bytes_q)) dl_bytes_q <= dl_bytes_q + 1'b1;
        if (push_req && (!in_range || fifo_full)) dl_error_q <= 1'b1;
      end
    end
  end

  assign ioctl_wait = ioctl_wait_q;
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_index   = dn_index_q;
  assign dl_bytes   = dl_bytes_q;
  assign dl_error   = dl_error_q;
  assign dl_active  = (state_q != StIdle);
  assign dl_done    = (state_q == StDone);

endmodule

// File: tb/tb_ioctl_dl_bridge.sv
// Directed bench for ioctl_dl_bridge: inputs change and outputs are checked on the falling edge.
module tb_ioctl_dl_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout, ioctl_index;
  logic        ioctl_wait, dn_ready;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data, dn_index;
  logic        dn_wr, dl_active, dl_done, dl_error;
  logic [24:0] dl_bytes;

  int n_tests = 0;
  int n_fail  = 0;

  ioctl_dl_bridge #(
    .DEPTH  (4),
    .ADDR_W (17)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .ioctl_wait     (ioctl_wait),
    .dn_ready       (dn_ready),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_index       (dn_index),
    .dn_wr          (dn_wr),
    .dl_active      (dl_active),
    .dl_done        (dl_done),
    .dl_bytes       (dl_bytes),
    .dl_error       (dl_error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"},   32'(ioctl_wait), 0);
    check({tag, "_wr"},     32'(dn_wr), 0);
    check({tag, "_addr"},   32'(dn_addr), 0);
    check({tag, "_data"},   32'(dn_data), 0);
    check({tag, "_index"},  32'(dn_index), 0);
    check({tag, "_active"}, 32'(dl_active), 0);
    check({tag, "_done"},   32'(dl_done), 0);
    check({tag, "_bytes"},  32'(dl_bytes), 0);
    check({tag, "_error"},  32'(dl_error), 0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    ioctl_wr       = 1'b0;
    cyc();
    check("start_active", 32'(dl_active), 1);
    check("start_index",  32'(dn_index), 32'(idx));
    check("start_err",    32'(dl_error), 0);
    check("start_bytes",  32'(dl_bytes), 0);
  endtask

  // Drop download with the FIFO already empty: DRAIN next, DONE after, then IDLE.
  task automatic end_dl();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    cyc();
    check("drain_wr",     32'(dn_wr), 0);
    check("drain_done",   32'(dl_done), 0);
    check("drain_active", 32'(dl_active), 1);
    cyc();
    check("done_pulse",   32'(dl_done), 1);
    check("done_active",  32'(dl_active), 1);
    cyc();
    check("idle_done",    32'(dl_done), 0);
    check("idle_active",  32'(dl_active), 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    dn_ready       = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc();

    // Single byte
    dn_ready = 1'b1;
    start_dl(8'd2);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h00010;
    ioctl_dout = 8'hA5;
    cyc();
    check("single_wr",    32'(dn_wr), 1);
    check("single_addr",  32'(dn_addr), 32'h10);
    check("single_data",  32'(dn_data), 32'hA5);
    check("single_bytes", 32'(dl_bytes), 1);
    end_dl();
    check("single_hold_addr", 32'(dn_addr), 32'h10);
    check("single_index",     32'(dn_index), 2);
    check("single_bytes_end", 32'(dl_bytes), 1);

    // Back-pressure
    dn_ready = 1'b0;
    start_dl(8'd5);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h100 + 25'(i);
      ioctl_dout = 8'h11 * 8'(i + 1);
      cyc();
      check("bp_wait", 32'(ioctl_wait), (i == 2) ? 1 : 0);
      check("bp_nowr", 32'(dn_wr), 0);
    end
    ioctl_wr = 1'b0;
    dn_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("bp_wr",   32'(dn_wr), 1);
      check("bp_addr", 32'(dn_addr), 32'h100 + i);
      check("bp_data", 32'(dn_data), 32'h11 * (i + 1));
      check("bp_wait_clr", 32'(ioctl_wait), 0);
    end
    end_dl();
    check("bp_bytes", 32'(dl_bytes), 3);
    check("bp_err",   32'(dl_error), 0);

    // Overflow: fifth write lands on a full FIFO
    dn_ready = 1'b0;
    start_dl(8'd7);
    for (int i = 0; i < 5; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h200 + 25'(i);
      ioctl_dout = 8'h40 + 8'(i);
      cyc();
      check("ovf_wait", 32'(ioctl_wait), (i >= 2) ? 1 : 0);
      check("ovf_err",  32'(dl_error), (i == 4) ? 1 : 0);
    end
    ioctl_wr = 1'b0;
    dn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("ovf_wr",   32'(dn_wr), 1);
      check("ovf_addr", 32'(dn_addr), 32'h200 + i);
      check("ovf_data", 32'(dn_data), 32'h40 + i);
    end
    end_dl();
    check("ovf_bytes",  32'(dl_bytes), 4);
    check("ovf_sticky", 32'(dl_error), 1);

    // Out-of-range address; start also clears the previous error
    start_dl(8'd3);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h20000;
    ioctl_dout = 8'h55;
    cyc();
    check("range_nowr",  32'(dn_wr), 0);
    check("range_err",   32'(dl_error), 1);
    check("range_bytes", 32'(dl_bytes), 0);
    end_dl();
    check("range_sticky", 32'(dl_error), 1);

    // Streaming 256 bytes back to back
    start_dl(8'd9);
    for (int i = 0; i <= 256; i++) begin
      if (i > 0) begin
        check("stream_wr",   32'(dn_wr), 1);
        check("stream_addr", 32'(dn_addr), 32'(i - 1));
        check("stream_data", 32'(dn_data), 32'((i - 1) & 8'hFF) ^ 32'h5A);
        check("stream_wait", 32'(ioctl_wait), 0);
      end
      if (i < 256) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(i);
        ioctl_dout = 8'(i) ^ 8'h5A;
        cyc();
      end
    end
    end_dl();
    check("stream_bytes", 32'(dl_bytes), 256);
    check("stream_err",   32'(dl_error), 0);

    // Reset with two bytes buffered and a third in flight
    dn_ready = 1'b0;
    start_dl(8'h0C);
    for (int i = 0; i < 2; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h300 + 25'(i);
      ioctl_dout = 8'hC0 + 8'(i);
      cyc();
    end
    ioctl_addr = 25'h302;
    ioctl_dout = 8'hC2;
    reset_n    = 1'b0;
    #1;
    check_all_zero("rst_async");
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    dn_ready       = 1'b1;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("rst_nowr",   32'(dn_wr), 0);
      check("rst_idle",   32'(dl_active), 0);
      check("rst_bytes",  32'(dl_bytes), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
